reg_sequencer: RTL and testbench
================================

# reg_sequencer

Multi-cycle control sequencer for the 8-register CPU register file. It accepts instruction bytes over a valid/ready handshake and decodes them. It drives the register file's write port (we/iaddr/idata) and read port (oe/oaddr), and steers ALU results into the accumulator (R0). It sits between the instruction source (ROM fetch or debug loader) and the register file/ALU pair, and is the only master of the register-file control lines.

## Interface
Parameters:
- DW, 8, data width of the register file and instruction bytes
- AW, 3, register address width (8 registers)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr  in  DW  instruction or immediate byte
- instr_valid  in  1  instr holds a byte
- instr_ready  out  1  sequencer accepts a byte this cycle
- rf_we  out  1  register-file write enable
- rf_iaddr  out  AW  register-file write address
- rf_idata  out  DW  register-file write data
- rf_oe  out  1  register-file output enable
- rf_oaddr  out  AW  register-file read address
- rf_odata  in  DW  register-file read data
- alu_op  out  3  ALU operation select
- alu_result  in  DW  ALU result, combinational from R0/R1
- zero  out  1  Z flag from the last ALU op
- err  out  1  sticky illegal-opcode flag
- halted  out  1  sequencer is in HALT

## Operation
Instruction byte decode:
- 00 ddd sss = MOV Rd <- Rs
- 01 ddd xxx = LDI Rd <- next byte
- 10 ooo xxx = ALU op ooo, result to R0
- 11 000000 = NOP
- 11 111111 = HALT
- other 11 xxxxxx = illegal: set err, treat as NOP

States:
- FETCH: instr_ready=1. On accept, decode:
  - MOV -> EXEC
  - ALU -> EXEC
  - LDI -> IMM
  - NOP or illegal -> FETCH
  - HALT -> HALT
- IMM: instr_ready=1. On accept, capture the byte into the hold register -> WB.
- EXEC:
  - MOV: rf_oe=1, rf_oaddr=sss, capture rf_odata into hold.
  - ALU: alu_op=ooo, capture alu_result into hold, zero <= (alu_result==0).
  - Then -> WB.
- WB: rf_we=1, rf_idata=hold, rf_iaddr=ddd (MOV/LDI) or 0 (ALU) -> FETCH.
- HALT: all strobes low, instr_ready=0, halted=1. The only exit is rst.

Output rules:
- rf_we, rf_oe and instr_ready are decoded from state and are never asserted together with another strobe in the same cycle, except instr_ready with nothing.
- Outside their active state, rf_oaddr, rf_iaddr, rf_idata and alu_op are 0.
- err is set on an illegal opcode and cleared only by rst.
- MOV Rd,Rd is legal: Rd is rewritten with its own value.

## Timing
- Reset values: FETCH; instr_ready=1; rf_we=0, rf_oe=0; all addresses/data 0; alu_op=0; zero=0; err=0; halted=0.
- rst asserted mid-instruction: the pending write is abandoned, rf_we drops immediately (asynchronous), and no partial write occurs.
- Latency, accept edge to WB write edge:
  - MOV: 2 cycles
  - ALU: 2 cycles
  - LDI: 1 cycle after the immediate is accepted
- Throughput:
  - MOV/ALU: one instruction per 3 cycles
  - LDI: 3 cycles plus any immediate wait
  - NOP: 1 cycle
- IMM waits indefinitely for instr_valid. No timeout.
- A write in WB is visible to a read in the next instruction's EXEC (no hazard).

## Configuration
- REGSEQ_ICOUNT_EN defined:
  - adds output icount (16 bits, reset 0).
  - icount increments once per retired instruction: MOV and LDI in WB, ALU in WB, NOP/illegal in FETCH on accept, HALT on entry.
  - icount wraps 0xFFFF -> 0x0000.
- Undefined: no icount port or counter logic.

## Structure
- Shared package reg_seq_pkg holds:
  - the opcode-class constants (OP_MOV, OP_LDI, OP_ALU, OP_SYS)
  - the NOP/HALT encodings
  - the state enum (FETCH, IMM, EXEC, WB, HALT)
  - the accumulator address constant ACC_ADDR=0
- One sub-module, reg_seq_decode: purely combinational, maps an instruction byte to class, dst, src, alu_op, illegal and halt.
- The FSM, hold register and flags stay in reg_sequencer.

## Test plan
- Reset, then LDI: bytes 0x48, 0x5A (LDI R1,0x5A) -> WB cycle has rf_we=1, rf_iaddr=1, rf_idata=0x5A. instr_ready is low only in WB.
- MOV: 0x11 (MOV R2,R1) with rf_odata=0x5A -> EXEC has rf_oe=1, rf_oaddr=1; WB has rf_we=1, rf_iaddr=2, rf_idata=0x5A.
- ALU zero: 0x98 (op 3) with alu_result=0x00 -> alu_op=3 in EXEC; WB writes R0=0x00; zero=1. A following op with alu_result=0x07 clears zero.
- Illegal then NOP: 0xC5, then 0xC0 -> err=1 and stays 1, no rf_we. FETCH ready every cycle.
- HALT and reset: 0xFF -> halted=1 and instr_ready=0 for 10 cycles. Asserting rst during a MOV WB cycle -> rf_we=0 immediately; after release, FETCH, halted=0, err=0.
- With REGSEQ_ICOUNT_EN: LDI, MOV, NOP, ALU -> icount=4. Preload 0xFFFF -> one NOP wraps it to 0.

Source files
------------

// File: rtl/reg_seq_pkg.sv
// Shared opcode classes, fixed encodings, FSM states and the decoded-instruction
// bundle used by the register-file sequencer and its decoder.
package reg_seq_pkg;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  localparam logic [7:0] INSTR_NOP  = 8'hC0;
  localparam logic [7:0] INSTR_HALT = 8'hFF;

  localparam logic [2:0] ACC_ADDR = 3'd0;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    IMM   = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    HALT  = 3'd4
  } state_t;

  typedef struct packed {
    logic [1:0] cls;
    logic [2:0] dst;
    logic [2:0] src;
    logic [2:0] alu_op;
    logic       illegal;
    logic       halt;
  } dec_t;

endpackage

// File: rtl/reg_seq_decode.sv
// Combinational instruction-byte decoder: splits the byte into class/fields and
// flags the HALT encoding and unused system opcodes. Zero latency, no handshake.
module reg_seq_decode
  import reg_seq_pkg::*;
(
  input  logic [7:0] instr,
  output dec_t       dec
);

  logic is_sys;

  always_comb begin
    is_sys      = (instr[7:6] == OP_SYS);
    dec         = '0;
    dec.cls     = instr[7:6];
    dec.dst     = instr[5:3];
    dec.src     = instr[2:0];
    dec.alu_op  = instr[5:3];
    dec.halt    = (instr == INSTR_HALT);
    // Only the two reserved system encodings are legal; the rest fall back to NOP.
    dec.illegal = is_sys && (instr != INSTR_NOP) && (instr != INSTR_HALT);
  end

endmodule

// File: rtl/reg_sequencer.sv
// Multi-cycle register-file sequencer: MOV/ALU write 2 cycles after accept, LDI 1 cycle after
// its immediate; instr_ready only in FETCH/IMM, HALT holds until rst. Option: REGSEQ_ICOUNT_EN.
module reg_sequencer
  import reg_seq_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_iaddr,
  output logic [DW-1:0] rf_idata,
  output logic          rf_oe,
  output logic [AW-1:0] rf_oaddr,
  input  logic [DW-1:0] rf_odata,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  output logic          zero,
  output logic          err,
  output logic          halted
`ifdef REGSEQ_ICOUNT_EN
  ,
  output logic [15:0]   icount
`endif
);

  state_t        state, state_nxt;
  dec_t          dec;
  logic [1:0]    cls_q;
  logic [2:0]    dst_q;
  logic [2:0]    src_q;
  logic [2:0]    op_q;
  logic [DW-1:0] hold;
  logic          accept;

  reg_seq_decode u_decode (
    .instr (instr[7:0]),
    .dec   (dec)
  );

  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (accept) begin
          case (dec.cls)
            OP_MOV, OP_ALU: state_nxt = EXEC;
            OP_LDI:         state_nxt = IMM;
            default:        state_nxt = dec.halt ? HALT : FETCH;
          endcase
        end
      end
      IMM:     if (accept) state_nxt = WB;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // Strobes depend only on state so rst drops rf_we in the same instant it clears state.
  always_comb begin
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    rf_iaddr    = '0;
    rf_idata    = '0;
    rf_oe       = 1'b0;
    rf_oaddr    = '0;
    alu_op      = '0;
    halted      = 1'b0;
    case (state)
      FETCH, IMM: instr_ready = 1'b1;
      EXEC: begin
        if (cls_q == OP_MOV) begin
          rf_oe    = 1'b1;
          rf_oaddr = AW'(src_q);
        end else begin
          alu_op   = op_q;
        end
      end
      WB: begin
        rf_we    = 1'b1;
        rf_idata = hold;
        rf_iaddr = (cls_q == OP_ALU) ? AW'(ACC_ADDR) : AW'(dst_q);
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q <= OP_SYS;
      dst_q <= '0;
      src_q <= '0;
      op_q  <= '0;
      hold  <= '0;
      zero  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (accept) begin
            cls_q <= dec.cls;
            dst_q <= dec.dst;
            src_q <= dec.src;
            op_q  <= dec.alu_op;
            if (dec.illegal) err <= 1'b1;
          end
        end
        IMM: if (accept) hold <= instr;
        EXEC: begin
          if (cls_q == OP_MOV) begin
            hold <= rf_odata;
          end else begin
            hold <= alu_result;
            zero <= (alu_result == '0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REGSEQ_ICOUNT_EN
  logic retire;

  // NOP, illegal and HALT retire on accept; everything else retires in WB.
  assign retire = (state == WB) ||
                  ((state == FETCH) && accept && (dec.cls == OP_SYS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         icount <= '0;
    else if (retire) icount <= icount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench for reg_sequencer: LDI/MOV/ALU/illegal/HALT/reset vectors with
// hand-computed expectations; icount vectors run only when REGSEQ_ICOUNT_EN is defined.
module tb_reg_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       rf_we;
  logic [2:0] rf_iaddr;
  logic [7:0] rf_idata;
  logic       rf_oe;
  logic [2:0] rf_oaddr;
  logic [7:0] rf_odata;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       zero;
  logic       err;
  logic       halted;
`ifdef REGSEQ_ICOUNT_EN
  logic [15:0] icount;
`endif

  int checks = 0;
  int errors = 0;

  reg_sequencer #(.DW(8), .AW(3)) dut (
`ifdef REGSEQ_ICOUNT_EN
    .icount      (icount),
`endif
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .rf_we       (rf_we),
    .rf_iaddr    (rf_iaddr),
    .rf_idata    (rf_idata),
    .rf_oe       (rf_oe),
    .rf_oaddr    (rf_oaddr),
    .rf_odata    (rf_odata),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .zero        (zero),
    .err         (err),
    .halted      (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    instr       = 8'h00;
    instr_valid = 1'b0;
    rf_odata    = 8'h00;
    alu_result  = 8'h00;
    #1;
    check("rst_ready",  instr_ready, 1);
    check("rst_we",     rf_we,       0);
    check("rst_oe",     rf_oe,       0);
    check("rst_iaddr",  rf_iaddr,    0);
    check("rst_idata",  rf_idata,    0);
    check("rst_oaddr",  rf_oaddr,    0);
    check("rst_aluop",  alu_op,      0);
    check("rst_zero",   zero,        0);
    check("rst_err",    err,         0);
    check("rst_halted", halted,      0);
    tick();
    tick();
    rst = 1'b0;

    // LDI R1,0x5A
    instr = 8'h48; instr_valid = 1'b1;
    check("ldi_fetch_rdy", instr_ready, 1);
    tick();
    check("ldi_imm_rdy", instr_ready, 1);
    check("ldi_imm_we",  rf_we,       0);
    instr = 8'h5A;
    tick();
    instr_valid = 1'b0;
    check("ldi_wb_we",    rf_we,       1);
    check("ldi_wb_iaddr", rf_iaddr,    1);
    check("ldi_wb_idata", rf_idata,    8'h5A);
    check("ldi_wb_rdy",   instr_ready, 0);
    check("ldi_wb_oe",    rf_oe,       0);
    tick();
    check("ldi_back_rdy", instr_ready, 1);
    check("ldi_back_we",  rf_we,       0);

    // MOV R2,R1
    instr = 8'h11; instr_valid = 1'b1; rf_odata = 8'h5A;
    tick();
    instr_valid = 1'b0;
    check("mov_ex_oe",    rf_oe,       1);
    check("mov_ex_oaddr", rf_oaddr,    1);
    check("mov_ex_rdy",   instr_ready, 0);
    check("mov_ex_we",    rf_we,       0);
    tick();
    rf_odata = 8'h00;
    check("mov_wb_we",    rf_we,    1);
    check("mov_wb_iaddr", rf_iaddr, 2);
    check("mov_wb_idata", rf_idata, 8'h5A);
    check("mov_wb_oe",    rf_oe,    0);
    check("mov_wb_oaddr", rf_oaddr, 0);
    tick();

    // ALU op 3 producing zero, then op 0 producing 0x07
    instr = 8'h98; instr_valid = 1'b1; alu_result = 8'h00;
    tick();
    instr_valid = 1'b0;
    check("alu_ex_op", alu_op, 3);
    check("alu_ex_oe", rf_oe,  0);
    tick();
    alu_result = 8'h33;
    check("alu_wb_we",    rf_we,    1);
    check("alu_wb_iaddr", rf_iaddr, 0);
    check("alu_wb_idata", rf_idata, 0);
    check("alu_wb_zero",  zero,     1);
    check("alu_wb_op",    alu_op,   0);
    tick();
    instr = 8'hA8; instr_valid = 1'b1; alu_result = 8'h07;
    tick();
    instr_valid = 1'b0;
    check("alu2_ex_op", alu_op, 5);
    tick();
    check("alu2_wb_idata", rf_idata, 8'h07);
    check("alu2_wb_zero",  zero,     0);
    tick();

    // Illegal then NOP: single-cycle each, no write
    instr = 8'hC5; instr_valid = 1'b1;
    tick();
    check("ill_err", err,         1);
    check("ill_rdy", instr_ready, 1);
    check("ill_we",  rf_we,       0);
    instr = 8'hC0;
    tick();
    instr_valid = 1'b0;
    check("nop_err", err,         1);
    check("nop_rdy", instr_ready, 1);
    check("nop_we",  rf_we,       0);
    tick();
    check("nop_idle_err", err, 1);

    // Reset during MOV write-back
    instr = 8'h11; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("mrst_wb_we", rf_we, 1);
    rst = 1'b1;
    #1;
    check("mrst_async_we", rf_we, 0);
    tick();
    rst = 1'b0;
    check("mrst_err",    err,         0);
    check("mrst_halted", halted,      0);
    check("mrst_rdy",    instr_ready, 1);
    tick();
    check("mrst_no_we",  rf_we,       0);

    // HALT holds for good, even with valid bytes offered
    instr = 8'hFF; instr_valid = 1'b1;
    tick();
    instr = 8'h48;
    for (int i = 0; i < 10; i++) begin
      check("halt_halted", halted,      1);
      check("halt_rdy",    instr_ready, 0);
      check("halt_we",     rf_we,       0);
      tick();
    end
    instr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("halt_rst_halted", halted,      0);
    check("halt_rst_rdy",    instr_ready, 1);

`ifdef REGSEQ_ICOUNT_EN
    check("ic_rst", icount, 0);
    instr = 8'h48; instr_valid = 1'b1;
    tick();
    instr = 8'h5A;
    tick();
    instr_valid = 1'b0;
    tick();
    check("ic_ldi", icount, 1);
    instr = 8'h11; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    instr = 8'hC0; instr_valid = 1'b1;
    tick();
    instr = 8'h80;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check("ic_four", icount, 4);
    instr = 8'hC0; instr_valid = 1'b1;
    repeat (65531) tick();
    check("ic_max", icount, 16'hFFFF);
    tick();
    instr_valid = 1'b0;
    check("ic_wrap", icount, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
